// File: rtl/cond_sub_pkg.sv
// Shared types for the conditional-subtract pipeline.
package cond_sub_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    SUB       = 2'd0,
    SUB_INC_Z = 2'd1,
    ABSDIFF   = 2'd2,
    SAT_SUB   = 2'd3
  } cond_sub_op_e;

endpackage

// File: rtl/cond_sub_core.sv
// Combinational subtract with post-adjust; flags always describe the raw a-b.
module cond_sub_core
  import cond_sub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             zero,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             ovf
);

  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] d_lo;
  cond_sub_op_e     op_e;

  assign op_e = cond_sub_op_e'(op);

  // Raw difference, flags, then mode-dependent adjust of the low WIDTH bits.
  always_comb begin
    diff   = {1'b0, a} - {1'b0, b};
    d_lo   = diff[WIDTH-1:0];
    borrow = diff[WIDTH];
    ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (d_lo[WIDTH-1] != a[WIDTH-1]);
    result = d_lo;
    unique case (op_e)
      SUB:       result = d_lo;
      SUB_INC_Z: result = d_lo + {{(WIDTH-1){1'b0}}, zero};
      ABSDIFF:   result = borrow ? (b - a) : d_lo;
      SAT_SUB:   result = borrow ? '0 : d_lo;
      default:   result = d_lo;
    endcase
  end

endmodule

// File: rtl/cond_sub_pipe.sv
// Two-stage valid/ready subtract pipeline: S1 holds operands, S2 holds results.
module cond_sub_pipe
  import cond_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_zero,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_zero,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic             s1_zero_q, s1_zero_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;

  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d, s2_a_q, s2_a_d, s2_b_q, s2_b_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_borrow_q, s2_borrow_d;
  logic             s2_ovf_q, s2_ovf_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept, consume, s2_adv;
  logic [WIDTH-1:0] core_res;
  logic             core_borrow, core_ovf;

  cond_sub_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .zero   (s1_zero_q),
    .op     (s1_op_q),
    .result (core_res),
    .borrow (core_borrow),
    .ovf    (core_ovf)
  );

  // Handshake: S1 may move into S2 when S2 is empty or being drained.
  always_comb begin
    s2_adv   = s1_v_q && (!s2_v_q || out_ready);
    in_ready = !s1_v_q || s2_adv;
    accept   = in_valid && in_ready;
    consume  = s2_v_q && out_ready;
  end

  // Next-state for both stages and the consume counter.
  always_comb begin
    s1_v_d      = s1_v_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_zero_d   = s1_zero_q;
    s1_op_d     = s1_op_q;
    s2_v_d      = s2_v_q;
    s2_res_d    = s2_res_q;
    s2_a_d      = s2_a_q;
    s2_b_d      = s2_b_q;
    s2_zero_d   = s2_zero_q;
    s2_borrow_d = s2_borrow_q;
    s2_ovf_d    = s2_ovf_q;
    cnt_d       = cnt_q;

    if (accept) begin
      s1_v_d    = 1'b1;
      s1_a_d    = in_a;
      s1_b_d    = in_b;
      s1_zero_d = in_zero;
      s1_op_d   = in_op;
    end else if (s2_adv) begin
      s1_v_d = 1'b0;
    end

    if (s2_adv) begin
      s2_v_d      = 1'b1;
      s2_res_d    = core_res;
      s2_a_d      = s1_a_q;
      s2_b_d      = s1_b_q;
      s2_zero_d   = (core_res == '0);
      s2_borrow_d = core_borrow;
      s2_ovf_d    = core_ovf;
    end else if (consume) begin
      s2_v_d = 1'b0;
    end

    if (consume) cnt_d = cnt_q + 1'b1;
  end

  // Pipeline registers; reset drops in-flight beats and clears data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_zero_q   <= 1'b0;
      s1_op_q     <= '0;
      s2_v_q      <= 1'b0;
      s2_res_q    <= '0;
      s2_a_q      <= '0;
      s2_b_q      <= '0;
      s2_zero_q   <= 1'b0;
      s2_borrow_q <= 1'b0;
      s2_ovf_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_zero_q   <= s1_zero_d;
      s1_op_q     <= s1_op_d;
      s2_v_q      <= s2_v_d;
      s2_res_q    <= s2_res_d;
      s2_a_q      <= s2_a_d;
      s2_b_q      <= s2_b_d;
      s2_zero_q   <= s2_zero_d;
      s2_borrow_q <= s2_borrow_d;
      s2_ovf_q    <= s2_ovf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_result = s2_res_q;
  assign out_a      = s2_a_q;
  assign out_b      = s2_b_q;
  assign out_zero   = s2_zero_q;
  assign out_borrow = s2_borrow_q;
  assign out_ovf    = s2_ovf_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_cond_sub_pipe.sv
// Bench for cond_sub_pipe: directed vector table, corner sequences, random scoreboard.
module tb_cond_sub_pipe;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_zero;
  logic [WIDTH-1:0] in_a, in_b;
  logic [1:0]       in_op;
  logic             out_valid, out_ready, out_zero, out_borrow, out_ovf;
  logic [WIDTH-1:0] out_result, out_a, out_b;
  logic [CNT_W-1:0] op_count;

  cond_sub_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_zero(in_zero), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_a(out_a), .out_b(out_b), .out_zero(out_zero),
    .out_borrow(out_borrow), .out_ovf(out_ovf), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, res;
    logic        zero, borrow, ovf;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        zin;
    logic [31:0] res;
    logic        borrow, ovf, zero;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cons  = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the mode definitions.
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic z, logic [1:0] op);
    exp_t   e;
    longint sd;
    sd       = longint'($signed(a)) - longint'($signed(b));
    e.a      = a;
    e.b      = b;
    e.borrow = (a < b);
    e.ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    case (op)
      2'd0:    e.res = a - b;
      2'd1:    e.res = a - b + {31'd0, z};
      2'd2:    e.res = (a < b) ? (b - a) : (a - b);
      default: e.res = (a < b) ? 32'd0 : (a - b);
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // One clock: scoreboard checks before the edge, counter/hold checks after it.
  task automatic tick(output bit acc);
    exp_t        e;
    bit          stall;
    logic [31:0] held_r, held_a;
    #1;
    chk("in_ready_rule", in_ready, (q.size() < 2) || out_ready);
    if (q.size() == 0) chk("no_spurious_valid", out_valid, 1'b0);
    if (out_valid && out_ready && q.size() > 0) begin
      e = q.pop_front();
      chk("sb_result", out_result, e.res);
      chk("sb_a", out_a, e.a);
      chk("sb_b", out_b, e.b);
      chk("sb_flags", {out_zero, out_borrow, out_ovf}, {e.zero, e.borrow, e.ovf});
      cons++;
    end
    stall  = out_valid && !out_ready;
    held_r = out_result;
    held_a = out_a;
    acc    = in_valid && in_ready;
    if (acc) q.push_back(model(in_a, in_b, in_zero, in_op));
    @(posedge clk);
    #1;
    chk("op_count", op_count, cons % 16);
    if (stall) chk("hold_stable", {out_valid, out_result, out_a}, {1'b1, held_r, held_a});
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_op_count", op_count, 0);
    chk("rst_out_data", {out_result, out_a, out_b}, 96'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    cons = 0;
  endtask

  task automatic rnd_beat();
    in_op   = 2'($urandom_range(0, 3));
    in_zero = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 0) begin
      in_a = $urandom_range(0, 15);
      in_b = $urandom_range(0, 15);
    end else begin
      in_a = $urandom;
      in_b = $urandom;
    end
  endtask

  vec_t        vt[11];
  logic [31:0] bp_a[4], bp_b[4];
  bit          acc;
  int          k, sent, cons0;

  initial begin
    vt[0]  = '{2'd0, 32'd7, 32'd9, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{2'd1, 32'd5, 32'd5, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{2'd2, 32'd3, 32'd10, 1'b0, 32'd7, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{2'd3, 32'd3, 32'd10, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
    vt[4]  = '{2'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{2'd0, 32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{2'd2, 32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{2'd3, 32'd10, 32'd3, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{2'd1, 32'd0, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1};
    vt[9]  = '{2'd0, 32'd5, 32'd5, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{2'd2, 32'd0, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_zero = 1'b0; in_op = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Directed vectors, one beat at a time, with latency check.
    foreach (vt[i]) begin
      in_valid = 1'b1; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b; in_zero = vt[i].zin;
      tick(acc);
      chk("vec_accept", acc, 1'b1);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 5) begin tick(acc); k++; end
      chk("vec_latency", k, 1);
      chk("vec_result", out_result, vt[i].res);
      chk("vec_flags", {out_borrow, out_ovf, out_zero}, {vt[i].borrow, vt[i].ovf, vt[i].zero});
      tick(acc);
    end

    // Reset with two beats in flight: nothing may emerge afterwards.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin in_a = 100 + i; in_b = 1; in_op = 2'd0; tick(acc); end
    chk("inflight_before_rst", q.size(), 2);
    do_reset();
    out_ready = 1'b1;
    repeat (5) tick(acc);

    // Backpressure: only two beats fit while the consumer stalls.
    for (int i = 0; i < 4; i++) begin bp_a[i] = 32'h1000 + i; bp_b[i] = 32'h10 * i; end
    out_ready = 1'b0; sent = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = bp_a[sent]; in_b = bp_b[sent]; in_op = 2'd0; in_zero = 1'b0;
      tick(acc);
      if (acc) sent++;
    end
    chk("bp_accepted", sent, 2);
    #1;
    chk("bp_full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1; k = 0;
    while ((sent < 4 || q.size() > 0) && k < 20) begin
      in_valid = (sent < 4);
      if (sent < 4) begin in_a = bp_a[sent]; in_b = bp_b[sent]; end
      tick(acc);
      if (acc) sent++;
      k++;
    end
    chk("bp_drain_timeout", k < 20, 1'b1);
    chk("bp_op_count", op_count, 4);

    // Full throughput: 100 back-to-back beats.
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 103; t++) begin
      in_valid = (t < 100);
      rnd_beat();
      chk("tp_out_valid", out_valid, (t >= 2) && (t <= 101));
      tick(acc);
      if (t < 100) chk("tp_accept", acc, 1'b1);
    end

    // Counter wrap: 17 consumes on a 4-bit counter.
    do_reset();
    sent = 0; k = 0;
    while (cons < 17 && k < 40) begin
      in_valid = (sent < 17);
      rnd_beat();
      tick(acc);
      if (acc) sent++;
      k++;
    end
    chk("wrap_op_count", op_count, 1);

    // Random valid/ready traffic against the scoreboard.
    cons0 = cons;
    for (int t = 0; t < 400; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rnd_beat();
      tick(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick(acc);
    chk("rand_drained", q.size(), 0);
    chk("rand_progress", (cons - cons0) > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
